// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU: program memory geometry and the
// program loader state machine encoding.
package cpu8_pkg;

    localparam int unsigned INSTR_W         = 13;
    localparam int unsigned ADDR_W          = 8;
    localparam int unsigned PM_DEPTH        = 1 << ADDR_W;
    localparam logic [7:0]  SYNC_DEFAULT    = 8'hA5;
    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_ADDR,
        LD_COUNT,
        LD_DATA_HI,
        LD_DATA_LO,
        LD_CHECK
    } loader_state_e;

endpackage

// File: rtl/program_loader_timeout.sv
// Idle-cycle watchdog for the program loader: counts cycles without an
// accepted byte and flags expiry in the cycle that completes TIMEOUT of them.
module loader_timeout
    import cpu8_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational so the FSM acts on the same edge the TIMEOUT-th idle cycle ends.
    assign expired_o = en_i & ~clr_i & (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader writing 13-bit words into program memory while
// holding the CPU in reset until an image arrives with a good checksum.
module program_loader #(
    parameter int unsigned INSTR_W   = cpu8_pkg::INSTR_W,
    parameter int unsigned ADDR_W    = cpu8_pkg::ADDR_W,
    parameter logic [7:0]  SYNC_BYTE = cpu8_pkg::SYNC_DEFAULT,
    parameter int unsigned TIMEOUT   = cpu8_pkg::TIMEOUT_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [7:0]         byte_i,
    input  logic               byte_valid_i,
    output logic               byte_ready_o,
    output logic               pm_wr_en_o,
    output logic [ADDR_W-1:0]  pm_wr_addr_o,
    output logic [INSTR_W-1:0] pm_wr_data_o,
    output logic               cpu_hold_o,
    output logic               done_o,
    output logic               err_o
);

    import cpu8_pkg::*;

    localparam int unsigned HI_W = INSTR_W - 8;

    loader_state_e      state_q;
    logic               ready_q;
    logic [7:0]         chk_q;
    logic [ADDR_W-1:0]  ptr_q;
    logic [8:0]         cnt_q;
    logic [HI_W-1:0]    hi_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [INSTR_W-1:0] wr_data_q;
    logic               hold_q;
    logic               done_q;
    logic               err_q;

    logic accept;
    logic to_clr;
    logic to_en;
    logic to_expired;

    assign accept = byte_valid_i & ready_q;
    assign to_en  = (state_q != LD_IDLE);
    assign to_clr = accept | (state_q == LD_IDLE);

    loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (to_clr),
        .en_i      (to_en),
        .expired_o (to_expired)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= LD_IDLE;
            ready_q   <= 1'b0;
            chk_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (to_expired) begin
                // Hold stays asserted: the image in memory is incomplete.
                err_q   <= 1'b1;
                state_q <= LD_IDLE;
            end else if (accept) begin
                unique case (state_q)
                    LD_IDLE: begin
                        if (byte_i == SYNC_BYTE) begin
                            hold_q  <= 1'b1;
                            err_q   <= 1'b0;
                            chk_q   <= '0;
                            state_q <= LD_ADDR;
                        end
                    end
                    LD_ADDR: begin
                        ptr_q   <= ADDR_W'(byte_i);
                        chk_q   <= chk_q + byte_i;
                        state_q <= LD_COUNT;
                    end
                    LD_COUNT: begin
                        cnt_q   <= (byte_i == 8'h00) ? 9'(PM_DEPTH) : {1'b0, byte_i};
                        chk_q   <= chk_q + byte_i;
                        state_q <= LD_DATA_HI;
                    end
                    LD_DATA_HI: begin
                        hi_q    <= byte_i[HI_W-1:0];
                        chk_q   <= chk_q + byte_i;
                        state_q <= LD_DATA_LO;
                    end
                    LD_DATA_LO: begin
                        chk_q     <= chk_q + byte_i;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= ptr_q;
                        wr_data_q <= {hi_q, byte_i};
                        ptr_q     <= ptr_q + ADDR_W'(1);
                        cnt_q     <= cnt_q - 9'd1;
                        state_q   <= (cnt_q == 9'd1) ? LD_CHECK : LD_DATA_HI;
                    end
                    LD_CHECK: begin
                        if (byte_i == chk_q) begin
                            done_q <= 1'b1;
                            hold_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= LD_IDLE;
                    end
                    default: state_q <= LD_IDLE;
                endcase
            end
        end
    end

    assign byte_ready_o = ready_q;
    assign pm_wr_en_o   = wr_en_q;
    assign pm_wr_addr_o = wr_addr_q;
    assign pm_wr_data_o = wr_data_q;
    assign cpu_hold_o   = hold_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames from the test plan
// plus randomized frames checked against a frame-level reference parser.
module tb_program_loader;

    localparam int unsigned TO = 1024;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        pm_wr_en_o;
    logic [7:0]  pm_wr_addr_o;
    logic [12:0] pm_wr_data_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        err_o;

    always #5 clk = ~clk;

    program_loader #(
        .INSTR_W   (13),
        .ADDR_W    (8),
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .pm_wr_en_o   (pm_wr_en_o),
        .pm_wr_addr_o (pm_wr_addr_o),
        .pm_wr_data_o (pm_wr_data_o),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int got_wr[$];
    int exp_wr[$];
    int wr_cyc[$];
    logic [7:0] frame_q[$];

    // Observed writes are packed as addr*65536 + data.
    always @(negedge clk) begin
        cyc++;
        if (pm_wr_en_o === 1'b1) begin
            got_wr.push_back(int'(pm_wr_addr_o) * 65536 + int'(pm_wr_data_o));
            wr_cyc.push_back(cyc);
        end
        if (done_o === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    // Reference: skip to the first sync byte, then parse the frame by the format rules.
    function automatic bit model_frame();
        int i, a, n, sum, hi, lo;
        i = 0;
        while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
        a   = int'(frame_q[i+1]);
        n   = (frame_q[i+2] == 8'h00) ? 256 : int'(frame_q[i+2]);
        sum = int'(frame_q[i+1]) + int'(frame_q[i+2]);
        for (int k = 0; k < n; k++) begin
            hi  = int'(frame_q[i+3+2*k]);
            lo  = int'(frame_q[i+4+2*k]);
            sum = sum + hi + lo;
            exp_wr.push_back(((a + k) % 256) * 65536 + (hi % 32) * 256 + lo);
        end
        return (sum % 256) == int'(frame_q[i+3+2*n]);
    endfunction

    function automatic int first_wr_diff();
        int n;
        n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
        for (int k = 0; k < n; k++) if (got_wr[k] != exp_wr[k]) return k;
        if (got_wr.size() != exp_wr.size()) return n;
        return -1;
    endfunction

    function automatic void mk_frame(input int addr, input int n, input bit corrupt);
        int sum;
        logic [7:0] hi, lo, chk;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(addr));
        frame_q.push_back(8'(n % 256));
        sum = addr % 256 + n % 256;
        for (int k = 0; k < n; k++) begin
            hi = 8'($urandom_range(255, 0));
            lo = 8'($urandom_range(255, 0));
            frame_q.push_back(hi);
            frame_q.push_back(lo);
            sum = sum + int'(hi) + int'(lo);
        end
        chk = 8'(sum % 256);
        if (corrupt) chk = chk ^ 8'($urandom_range(255, 1));
        frame_q.push_back(chk);
    endfunction

    task automatic put(input logic [7:0] b);
        int unsigned guard;
        guard = 0;
        byte_i = b;
        byte_valid_i = 1'b1;
        while (byte_ready_o !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (byte_ready_o !== 1'b1) begin
            total++; bad++;
            $display("FAIL ready_wait got=%b exp=1", byte_ready_o);
        end
        @(negedge clk);
    endtask

    task automatic drive_frame(input int maxgap);
        foreach (frame_q[i]) begin
            repeat ($urandom_range(maxgap, 0)) begin
                byte_valid_i = 1'b0;
                @(negedge clk);
            end
            put(frame_q[i]);
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic start_frame();
        got_wr.delete();
        exp_wr.delete();
        wr_cyc.delete();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        byte_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({byte_ready_o, pm_wr_en_o, pm_wr_addr_o, pm_wr_data_o, cpu_hold_o, done_o, err_o} !== 26'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {byte_ready_o, pm_wr_en_o, pm_wr_addr_o, pm_wr_data_o, cpu_hold_o, done_o, err_o});
        end
        rst_ni = 1'b1;
        @(negedge clk);
        total++;
        if (byte_ready_o !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b exp=1", byte_ready_o); end
        total++;
        if ({cpu_hold_o, done_o, err_o, pm_wr_en_o} !== 4'b0000) begin
            bad++; $display("FAIL flags_after_reset got=%b exp=0000", {cpu_hold_o, done_o, err_o, pm_wr_en_o});
        end
    endtask

    task automatic test_good_load();
        int d0, dw;
        bit ok;
        start_frame();
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h14, 8'h09, 8'h00, 8'h00, 8'h1F};
        ok = model_frame();
        d0 = done_cnt;
        foreach (frame_q[i]) begin
            put(frame_q[i]);
            if (i == 0) begin
                total++;
                if (cpu_hold_o !== 1'b1) begin bad++; $display("FAIL good_hold_rise got=%b exp=1", cpu_hold_o); end
            end
            if (i == 4) begin
                total++;
                if (pm_wr_en_o !== 1'b1 || pm_wr_data_o !== 13'h1409) begin
                    bad++; $display("FAIL good_wr_timing got=%b/%h exp=1/1409", pm_wr_en_o, pm_wr_data_o);
                end
            end
        end
        byte_valid_i = 1'b0;
        total++;
        if (done_o !== ok || cpu_hold_o !== !ok) begin
            bad++; $display("FAIL good_done_timing got=%b/%b exp=%b/%b", done_o, cpu_hold_o, ok, !ok);
        end
        @(negedge clk);
        total++;
        if (done_o !== 1'b0) begin bad++; $display("FAIL good_done_width got=%b exp=0", done_o); end
        repeat (2) @(negedge clk);
        dw = first_wr_diff();
        total++;
        if (dw >= 0) begin bad++; $display("FAIL good_writes got_n=%0d exp_n=%0d first_diff=%0d", got_wr.size(), exp_wr.size(), dw); end
        total++;
        if (done_cnt - d0 != 1 || err_o !== 1'b0 || cpu_hold_o !== 1'b0) begin
            bad++; $display("FAIL good_end got=%0d/%b/%b exp=1/0/0", done_cnt - d0, err_o, cpu_hold_o);
        end
    endtask

    task automatic test_wrap();
        int d0, dw;
        bit ok;
        start_frame();
        frame_q = '{8'hA5, 8'hFF, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h04};
        ok = model_frame();
        d0 = done_cnt;
        drive_frame(0);
        repeat (3) @(negedge clk);
        dw = first_wr_diff();
        total++;
        if (dw >= 0) begin bad++; $display("FAIL wrap_writes got_n=%0d exp_n=%0d first_diff=%0d", got_wr.size(), exp_wr.size(), dw); end
        total++;
        if (got_wr.size() != 2 || got_wr[1] != 32'h0000_0002) begin
            bad++; $display("FAIL wrap_addr0 got_n=%0d exp=00:0002", got_wr.size());
        end
        total++;
        if (done_cnt - d0 != int'(ok) || err_o !== !ok || cpu_hold_o !== !ok) begin
            bad++; $display("FAIL wrap_end got=%0d/%b/%b exp=%0d/%b/%b", done_cnt - d0, err_o, cpu_hold_o, ok, !ok, !ok);
        end
    endtask

    task automatic test_bad_chk();
        int d0, dw;
        bit ok;
        start_frame();
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h07, 8'h00};
        ok = model_frame();
        d0 = done_cnt;
        drive_frame(0);
        total++;
        if (err_o !== !ok) begin bad++; $display("FAIL bad_err_timing got=%b exp=%b", err_o, !ok); end
        repeat (2) @(negedge clk);
        dw = first_wr_diff();
        total++;
        if (dw >= 0) begin bad++; $display("FAIL bad_writes got_n=%0d exp_n=%0d first_diff=%0d", got_wr.size(), exp_wr.size(), dw); end
        total++;
        if (done_cnt - d0 != int'(ok) || err_o !== !ok || cpu_hold_o !== !ok) begin
            bad++; $display("FAIL bad_end got=%0d/%b/%b exp=%0d/%b/%b", done_cnt - d0, err_o, cpu_hold_o, ok, !ok, !ok);
        end
        start_frame();
        mk_frame($urandom_range(255, 0), 3, 1'b0);
        ok = model_frame();
        d0 = done_cnt;
        drive_frame(2);
        repeat (2) @(negedge clk);
        total++;
        if (first_wr_diff() >= 0 || done_cnt - d0 != int'(ok) || err_o !== !ok || cpu_hold_o !== !ok) begin
            bad++; $display("FAIL bad_recover got=%0d/%b/%b exp=%0d/%b/%b", done_cnt - d0, err_o, cpu_hold_o, ok, !ok, !ok);
        end
    endtask

    task automatic test_garbage();
        int d0;
        bit ok;
        start_frame();
        frame_q = '{8'h00, 8'hFF, 8'h5A};
        drive_frame(0);
        repeat (2) @(negedge clk);
        total++;
        if (got_wr.size() != 0 || cpu_hold_o !== 1'b0) begin
            bad++; $display("FAIL garbage_ignored got=%0d/%b exp=0/0", got_wr.size(), cpu_hold_o);
        end
        frame_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h02, 8'h14, 8'h09, 8'h00, 8'h00, 8'h1F};
        ok = model_frame();
        d0 = done_cnt;
        frame_q = frame_q[3:$];
        drive_frame(1);
        repeat (2) @(negedge clk);
        total++;
        if (first_wr_diff() >= 0 || done_cnt - d0 != int'(ok) || cpu_hold_o !== !ok) begin
            bad++; $display("FAIL garbage_frame got=%0d/%b exp=%0d/%b", done_cnt - d0, cpu_hold_o, ok, !ok);
        end
    endtask

    task automatic test_timeout();
        int d0;
        bit ok;
        start_frame();
        put(8'hA5);
        put(8'h03);
        byte_valid_i = 1'b0;
        repeat (TO - 1) @(negedge clk);
        total++;
        if (err_o !== 1'b0 || cpu_hold_o !== 1'b1) begin
            bad++; $display("FAIL timeout_early got=%b/%b exp=0/1", err_o, cpu_hold_o);
        end
        @(negedge clk);
        total++;
        if (err_o !== 1'b1 || cpu_hold_o !== 1'b1) begin
            bad++; $display("FAIL timeout_expire got=%b/%b exp=1/1", err_o, cpu_hold_o);
        end
        repeat (3) @(negedge clk);
        total++;
        if (got_wr.size() != 0) begin bad++; $display("FAIL timeout_nowrite got=%0d exp=0", got_wr.size()); end
        mk_frame($urandom_range(255, 0), 2, 1'b0);
        ok = model_frame();
        d0 = done_cnt;
        drive_frame(0);
        repeat (2) @(negedge clk);
        total++;
        if (first_wr_diff() >= 0 || done_cnt - d0 != int'(ok) || err_o !== !ok || cpu_hold_o !== !ok) begin
            bad++; $display("FAIL timeout_idle got=%0d/%b/%b exp=%0d/%b/%b", done_cnt - d0, err_o, cpu_hold_o, ok, !ok, !ok);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit ok;
        start_frame();
        frame_q = '{8'hA5, 8'h10, 8'h04, 8'h12};
        drive_frame(0);
        rst_ni = 1'b0;
        @(negedge clk);
        total++;
        if ({byte_ready_o, pm_wr_en_o, pm_wr_addr_o, pm_wr_data_o, cpu_hold_o, done_o, err_o} !== 26'd0) begin
            bad++; $display("FAIL rstmid_outputs got=%b exp=0", {byte_ready_o, pm_wr_en_o, pm_wr_addr_o, pm_wr_data_o, cpu_hold_o, done_o, err_o});
        end
        rst_ni = 1'b1;
        @(negedge clk);
        start_frame();
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h14, 8'h09, 8'h00, 8'h00, 8'h1F};
        ok = model_frame();
        d0 = done_cnt;
        drive_frame(0);
        repeat (2) @(negedge clk);
        total++;
        if (first_wr_diff() >= 0 || done_cnt - d0 != int'(ok) || cpu_hold_o !== !ok) begin
            bad++; $display("FAIL rstmid_reload got=%0d/%b exp=%0d/%b", done_cnt - d0, cpu_hold_o, ok, !ok);
        end
    endtask

    task automatic test_random();
        int d0, dw, n;
        bit ok;
        logic [7:0] g;
        for (int f = 0; f < 20; f++) begin
            start_frame();
            n = (f % 10 == 5) ? 256 : int'($urandom_range(8, 1));
            mk_frame($urandom_range(255, 0), n, $urandom_range(3, 0) == 0);
            if ($urandom_range(1, 0) == 1) begin
                g = 8'($urandom_range(255, 0));
                if (g == 8'hA5) g = 8'h00;
                frame_q.push_front(g);
            end
            ok = model_frame();
            d0 = done_cnt;
            drive_frame(3);
            repeat (2) @(negedge clk);
            dw = first_wr_diff();
            total++;
            if (dw >= 0) begin
                bad++; $display("FAIL rand%0d_writes got_n=%0d exp_n=%0d first_diff=%0d", f, got_wr.size(), exp_wr.size(), dw);
            end
            total++;
            if (done_cnt - d0 != int'(ok) || err_o !== !ok || cpu_hold_o !== !ok) begin
                bad++; $display("FAIL rand%0d_end got=%0d/%b/%b exp=%0d/%b/%b", f, done_cnt - d0, err_o, cpu_hold_o, ok, !ok, !ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok, spaced;
        start_frame();
        mk_frame($urandom_range(255, 0), 6, 1'b0);
        ok = model_frame();
        drive_frame(0);
        repeat (2) @(negedge clk);
        total++;
        if (first_wr_diff() >= 0 || cpu_hold_o !== !ok) begin
            bad++; $display("FAIL b2b_writes got_n=%0d exp_n=%0d", got_wr.size(), exp_wr.size());
        end
        spaced = (wr_cyc.size() == 6);
        for (int k = 1; k < wr_cyc.size(); k++) if (wr_cyc[k] - wr_cyc[k-1] != 2) spaced = 1'b0;
        total++;
        if (!spaced) begin bad++; $display("FAIL b2b_spacing got_n=%0d exp=6 writes every 2 cycles", wr_cyc.size()); end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_wrap();
        test_bad_chk();
        test_garbage();
        test_timeout();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
